// File: rtl/alu_ex_stage.sv
// ALU execute stage: decodes aluControl, computes result/flags, and buffers them in a 2-entry in-order queue.
// Optional macro ALU_EX_OVF_EN adds a stored signed-overflow bit and the overflow output port.
module alu_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [2:0]       aluControl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [RD_W-1:0]  rdIn,
  input  logic             regWriteIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] aluResult,
  output logic             zero,
  output logic [RD_W-1:0]  rdOut,
  output logic             regWriteOut,
  output logic             illegalOp
`ifdef ALU_EX_OVF_EN
  ,
  output logic             overflow
`endif
);

  // Entry layout, LSB first: result | rd | regWrite | zero | illegal | (overflow)
  localparam int RD_LSB  = WIDTH;
  localparam int RW_BIT  = WIDTH + RD_W;
  localparam int Z_BIT   = RW_BIT + 1;
  localparam int IL_BIT  = RW_BIT + 2;
`ifdef ALU_EX_OVF_EN
  localparam int OV_BIT  = RW_BIT + 3;
  localparam int ENT_W   = WIDTH + RD_W + 4;
`else
  localparam int ENT_W   = WIDTH + RD_W + 3;
`endif

  logic [1:0]       r_count;
  logic [ENT_W-1:0] r_e0;
  logic [ENT_W-1:0] r_e1;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_lt;
  logic [WIDTH-1:0] w_res;
  logic             w_ill;
  logic [ENT_W-1:0] w_new;
  logic [ENT_W-1:0] w_head;
  logic             w_push;
  logic             w_pop;

  assign w_sum  = srcA + srcB;
  assign w_diff = srcA - srcB;
  assign w_lt   = $signed(srcA) < $signed(srcB);

  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    case (aluControl)
      3'b000:  w_res = w_sum;
      3'b001:  w_res = w_diff;
      3'b010:  w_res = srcA & srcB;
      3'b011:  w_res = srcA | srcB;
      3'b101:  w_res = {{(WIDTH-1){1'b0}}, w_lt};
      default: w_ill = 1'b1;
    endcase
  end

`ifdef ALU_EX_OVF_EN
  logic w_ovf;

  always_comb begin
    w_ovf = 1'b0;
    case (aluControl)
      3'b000:  w_ovf = (srcA[WIDTH-1] == srcB[WIDTH-1]) && (w_sum[WIDTH-1] != srcA[WIDTH-1]);
      3'b001:  w_ovf = (srcA[WIDTH-1] != srcB[WIDTH-1]) && (w_diff[WIDTH-1] != srcA[WIDTH-1]);
      default: w_ovf = 1'b0;
    endcase
  end

  assign w_new = {w_ovf, w_ill, (w_res == '0), regWriteIn, rdIn, w_res};
`else
  assign w_new = {w_ill, (w_res == '0), regWriteIn, rdIn, w_res};
`endif

  // inReady depends only on occupancy and reset, never on outReady.
  assign inReady  = (r_count < 2'd2) && !reset;
  assign outValid = (r_count != 2'd0);
  assign w_push   = inValid && inReady && !flush;
  assign w_pop    = outValid && outReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 2'd0;
      r_e0    <= '0;
      r_e1    <= '0;
    end else if (flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b01: begin
          r_e0    <= r_e1;
          r_count <= r_count - 2'd1;
        end
        2'b10: begin
          if (r_count == 2'd0) r_e0 <= w_new;
          else                 r_e1 <= w_new;
          r_count <= r_count + 2'd1;
        end
        // Push and pop together only happens at count 1: new entry replaces the head.
        2'b11: r_e0 <= w_new;
        default: ;
      endcase
    end
  end

  assign w_head      = outValid ? r_e0 : '0;
  assign aluResult   = w_head[WIDTH-1:0];
  assign rdOut       = w_head[RD_LSB +: RD_W];
  assign regWriteOut = w_head[RW_BIT];
  assign zero        = w_head[Z_BIT];
  assign illegalOp   = w_head[IL_BIT];
`ifdef ALU_EX_OVF_EN
  assign overflow    = w_head[OV_BIT];
`endif

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed self-checking bench for alu_ex_stage; overflow checks compile in with ALU_EX_OVF_EN.
module tb_alu_ex_stage;
  logic        clk = 1'b0;
  logic        reset, flush, inValid, inReady, outValid, outReady;
  logic [2:0]  aluControl;
  logic [31:0] srcA, srcB, aluResult;
  logic [4:0]  rdIn, rdOut;
  logic        regWriteIn, zero, regWriteOut, illegalOp;
`ifdef ALU_EX_OVF_EN
  logic        overflow;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_ex_stage #(.WIDTH(32), .RD_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .inValid(inValid), .inReady(inReady),
    .aluControl(aluControl), .srcA(srcA), .srcB(srcB),
    .rdIn(rdIn), .regWriteIn(regWriteIn),
    .outValid(outValid), .outReady(outReady),
    .aluResult(aluResult), .zero(zero), .rdOut(rdOut),
    .regWriteOut(regWriteOut), .illegalOp(illegalOp)
`ifdef ALU_EX_OVF_EN
    , .overflow(overflow)
`endif
  );

  localparam int NV = 11;
  localparam logic [2:0]  V_CTL [NV] = '{3'b001, 3'b101, 3'b010, 3'b011, 3'b110, 3'b100,
                                         3'b111, 3'b101, 3'b000, 3'b001, 3'b101};
  localparam logic [31:0] V_A   [NV] = '{32'd9, 32'hFFFFFFFF, 32'hF0F0, 32'hF0F0, 32'h12, 32'd1,
                                         32'd5, 32'd1, 32'hFFFFFFFF, 32'd0, 32'h80000000};
  localparam logic [31:0] V_B   [NV] = '{32'd9, 32'd1, 32'h0FF0, 32'h0FF0, 32'h34, 32'd1,
                                         32'd5, 32'hFFFFFFFF, 32'd1, 32'd1, 32'h7FFFFFFF};
  localparam logic [31:0] V_R   [NV] = '{32'd0, 32'd1, 32'h00F0, 32'hFFF0, 32'd0, 32'd0,
                                         32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd1};
  localparam logic        V_Z   [NV] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic        V_IL  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic rw);
    inValid = 1'b1; aluControl = ctl; srcA = a; srcB = b; rdIn = rd; regWriteIn = rw;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; outReady = 1'b1;
    drive(3'b000, 32'd1, 32'd2, 5'd1, 1'b1);
    tick(); tick();
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL reset_outValid got=%0h exp=0", outValid); end
    checks++; if (inReady !== 1'b0) begin failures++; $display("FAIL reset_inReady got=%0h exp=0", inReady); end
    checks++; if (aluResult !== 32'd0 || zero !== 1'b0 || rdOut !== 5'd0 || regWriteOut !== 1'b0 || illegalOp !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got=%0h/%0h/%0h/%0h/%0h exp=0", aluResult, zero, rdOut, regWriteOut, illegalOp); end
    inValid = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL reset_release_inReady got=%0h exp=1", inReady); end
    tick();
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL reset_no_stale_entry got=%0h exp=0", outValid); end
  endtask

  task automatic test_add();
    outReady = 1'b1;
    drive(3'b000, 32'd5, 32'd7, 5'd3, 1'b1);
    tick();
    inValid = 1'b0;
    checks++; if (outValid !== 1'b1) begin failures++; $display("FAIL add_outValid got=%0h exp=1", outValid); end
    checks++; if (aluResult !== 32'd12 || zero !== 1'b0) begin failures++; $display("FAIL add_result got=%0h z=%0h exp=c z=0", aluResult, zero); end
    checks++; if (rdOut !== 5'd3 || regWriteOut !== 1'b1 || illegalOp !== 1'b0) begin
      failures++; $display("FAIL add_tags got=%0h/%0h/%0h exp=3/1/0", rdOut, regWriteOut, illegalOp); end
    tick();
    checks++; if (outValid !== 1'b0 || aluResult !== 32'd0 || rdOut !== 5'd0 || regWriteOut !== 1'b0) begin
      failures++; $display("FAIL add_drain got=%0h/%0h/%0h/%0h exp=0", outValid, aluResult, rdOut, regWriteOut); end
  endtask

  task automatic test_alu_ops();
    outReady = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(V_CTL[i], V_A[i], V_B[i], 5'(i + 1), i[0]);
      tick();
      inValid = 1'b0;
      checks++; if (outValid !== 1'b1 || aluResult !== V_R[i]) begin
        failures++; $display("FAIL op%0d_result got=%0h v=%0h exp=%0h", i, aluResult, outValid, V_R[i]); end
      checks++; if (zero !== V_Z[i] || illegalOp !== V_IL[i]) begin
        failures++; $display("FAIL op%0d_flags got z=%0h il=%0h exp z=%0h il=%0h", i, zero, illegalOp, V_Z[i], V_IL[i]); end
      checks++; if (rdOut !== 5'(i + 1) || regWriteOut !== i[0]) begin
        failures++; $display("FAIL op%0d_tags got=%0h/%0h exp=%0h/%0h", i, rdOut, regWriteOut, i + 1, i[0]); end
`ifdef ALU_EX_OVF_EN
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL op%0d_overflow got=%0h exp=0", i, overflow); end
`endif
      tick();
    end
  endtask

  task automatic test_backpressure();
    outReady = 1'b0;
    drive(3'b000, 32'd1, 32'd1, 5'd1, 1'b1);
    tick();
    checks++; if (inReady !== 1'b1 || outValid !== 1'b1 || aluResult !== 32'd2) begin
      failures++; $display("FAIL bp_first got r=%0h v=%0h res=%0h exp 1/1/2", inReady, outValid, aluResult); end
    drive(3'b000, 32'd2, 32'd2, 5'd2, 1'b1);
    tick();
    checks++; if (inReady !== 1'b0 || aluResult !== 32'd2 || rdOut !== 5'd1) begin
      failures++; $display("FAIL bp_full got r=%0h res=%0h rd=%0h exp 0/2/1", inReady, aluResult, rdOut); end
    drive(3'b000, 32'd3, 32'd3, 5'd3, 1'b1);
    tick();
    checks++; if (inReady !== 1'b0 || aluResult !== 32'd2 || rdOut !== 5'd1) begin
      failures++; $display("FAIL bp_hold got r=%0h res=%0h rd=%0h exp 0/2/1", inReady, aluResult, rdOut); end
    outReady = 1'b1;
    tick();
    checks++; if (inReady !== 1'b1 || aluResult !== 32'd4 || rdOut !== 5'd2) begin
      failures++; $display("FAIL bp_pop1 got r=%0h res=%0h rd=%0h exp 1/4/2", inReady, aluResult, rdOut); end
    tick();
    inValid = 1'b0;
    checks++; if (outValid !== 1'b1 || aluResult !== 32'd6 || rdOut !== 5'd3) begin
      failures++; $display("FAIL bp_third got v=%0h res=%0h rd=%0h exp 1/6/3", outValid, aluResult, rdOut); end
    tick();
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0h exp=0", outValid); end
  endtask

  task automatic test_back_to_back();
    outReady = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      drive(3'b000, 32'(i * 3), 32'd10, 5'(i), 1'b1);
      tick();
      checks++; if (outValid !== 1'b1 || inReady !== 1'b1 || aluResult !== 32'(i * 3 + 10) || rdOut !== 5'(i)) begin
        failures++; $display("FAIL b2b_%0d got v=%0h r=%0h res=%0h rd=%0h exp 1/1/%0h/%0h",
                             i, outValid, inReady, aluResult, rdOut, i * 3 + 10, i); end
    end
    inValid = 1'b0;
    tick();
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%0h exp=0", outValid); end
  endtask

  task automatic test_flush();
    outReady = 1'b0;
    drive(3'b000, 32'd10, 32'd0, 5'd4, 1'b1);
    tick();
    drive(3'b000, 32'd20, 32'd0, 5'd5, 1'b1);
    tick();
    flush = 1'b1;
    drive(3'b000, 32'h55, 32'd0, 5'd7, 1'b1);
    tick();
    flush = 1'b0; inValid = 1'b0;
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1 || aluResult !== 32'd0) begin
      failures++; $display("FAIL flush_full got v=%0h r=%0h res=%0h exp 0/1/0", outValid, inReady, aluResult); end
    tick();
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL flush_full_drop got=%0h exp=0", outValid); end
    drive(3'b000, 32'd10, 32'd0, 5'd4, 1'b1);
    tick();
    flush = 1'b1;
    drive(3'b000, 32'h77, 32'd0, 5'd6, 1'b1);
    tick();
    flush = 1'b0; inValid = 1'b0;
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL flush_push_drop got=%0h exp=0", outValid); end
    tick();
    checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL flush_push_late got=%0h exp=0", outValid); end
    outReady = 1'b1;
  endtask

  task automatic test_reset_mid();
    outReady = 1'b0;
    drive(3'b000, 32'h7FFFFFFF, 32'd1, 5'd9, 1'b1);
    tick();
    drive(3'b001, 32'h80000000, 32'd1, 5'd10, 1'b1);
    tick();
    checks++; if (outValid !== 1'b1 || aluResult !== 32'h80000000) begin
      failures++; $display("FAIL rmid_pre got v=%0h res=%0h exp 1/80000000", outValid, aluResult); end
`ifdef ALU_EX_OVF_EN
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL rmid_pre_overflow got=%0h exp=1", overflow); end
`endif
    reset = 1'b1;
    tick();
    checks++; if (outValid !== 1'b0 || inReady !== 1'b0 || aluResult !== 32'd0 || rdOut !== 5'd0) begin
      failures++; $display("FAIL rmid_reset got v=%0h r=%0h res=%0h rd=%0h exp 0", outValid, inReady, aluResult, rdOut); end
`ifdef ALU_EX_OVF_EN
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rmid_overflow got=%0h exp=0", overflow); end
`endif
    reset = 1'b0; inValid = 1'b0;
    tick();
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin
      failures++; $display("FAIL rmid_after got v=%0h r=%0h exp 0/1", outValid, inReady); end
    outReady = 1'b1;
  endtask

`ifdef ALU_EX_OVF_EN
  task automatic test_overflow();
    outReady = 1'b1;
    drive(3'b000, 32'h7FFFFFFF, 32'd1, 5'd1, 1'b1);
    tick();
    checks++; if (overflow !== 1'b1 || aluResult !== 32'h80000000) begin
      failures++; $display("FAIL ovf_add got o=%0h res=%0h exp 1/80000000", overflow, aluResult); end
    drive(3'b001, 32'h80000000, 32'd1, 5'd2, 1'b1);
    tick();
    checks++; if (overflow !== 1'b1 || aluResult !== 32'h7FFFFFFF) begin
      failures++; $display("FAIL ovf_sub got o=%0h res=%0h exp 1/7fffffff", overflow, aluResult); end
    drive(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b1);
    tick();
    checks++; if (overflow !== 1'b0 || aluResult !== 32'hFFFFFFFE) begin
      failures++; $display("FAIL ovf_add_neg got o=%0h res=%0h exp 0/fffffffe", overflow, aluResult); end
    drive(3'b001, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd4, 1'b1);
    tick();
    checks++; if (overflow !== 1'b1 || aluResult !== 32'h80000000) begin
      failures++; $display("FAIL ovf_sub_pos got o=%0h res=%0h exp 1/80000000", overflow, aluResult); end
    drive(3'b011, 32'h7FFFFFFF, 32'd1, 5'd5, 1'b1);
    tick();
    inValid = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_or got=%0h exp=0", overflow); end
    tick();
    checks++; if (overflow !== 1'b0 || outValid !== 1'b0) begin
      failures++; $display("FAIL ovf_empty got o=%0h v=%0h exp 0/0", overflow, outValid); end
  endtask
`endif

  initial begin
    inValid = 1'b0; aluControl = 3'b000; srcA = '0; srcB = '0; rdIn = '0; regWriteIn = 1'b0;
    reset = 1'b1; flush = 1'b0; outReady = 1'b1;
    test_reset();
    test_add();
    test_alu_ops();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef ALU_EX_OVF_EN
    test_overflow();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
